// File: rtl/dmem_burst_master_pkg.sv
// Shared widths and FSM encodings for the data-memory burst master.
package dmem_burst_master_pkg;
    localparam int DMEM_ADDR_W = 11;
    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_LEN_W  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
endpackage

// File: rtl/dmem_burst_master_addr_counter.sv
// Loadable wrapping word address plus burst down-counter; last flags the final word.
module dmem_burst_master_addr_counter
    import dmem_burst_master_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int LEN_W  = DMEM_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [LEN_W-1:0] cnt;

    // Address wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= load_addr;
            cnt  <= load_len;
        end else begin
            if (inc) addr <= addr + 1'b1;
            if (dec) cnt  <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);
endmodule

// File: rtl/dmem_burst_master.sv
// Burst read/write initiator for the 2K x 16 distributed memory (async read, sync write).
module dmem_burst_master
    import dmem_burst_master_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int LEN_W  = DMEM_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              done,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_spo
);
    logic [1:0] state;
    logic       drain;
    logic       wlast;
    logic       we_q;
    logic       last;
    logic       accept;
    logic       cap;
    logic       wr_hs;

    // Holding off during the done cycle keeps a new accept strictly after done.
    assign req_ready = (state == ST_IDLE) && !done;
    assign accept    = req_valid && req_ready;
    assign wr_ready  = (state == ST_WR) && !wlast;
    assign wr_hs     = wr_valid && wr_ready;
    assign cap       = (state == ST_RD) && !drain && (!rd_valid || rd_ready);

    // Masking with reset stops the memory from writing on the reset edge itself.
    assign mem_we = we_q && !reset;

    dmem_burst_master_addr_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_addr (req_addr),
        .load_len  (req_len),
        .inc       (cap || ((state == ST_WR) && we_q)),
        .dec       (cap || wr_hs),
        .addr      (mem_a),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            drain    <= 1'b0;
            wlast    <= 1'b0;
            we_q     <= 1'b0;
            mem_d    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            we_q <= wr_hs;
            if (wr_hs) mem_d <= wr_data;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= req_write ? ST_WR : ST_RD;
                        drain <= 1'b0;
                        wlast <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (cap) begin
                        rd_data  <= mem_spo;
                        rd_valid <= 1'b1;
                        if (last) drain <= 1'b1;
                    end else if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        if (drain) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (wr_hs && last) wlast <= 1'b1;
                    // Final word's write edge: mem_a still points at its target here.
                    if (we_q && wlast) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_burst_master.sv
// Scoreboard bench: behavioural memory responder plus array model, monitor pops expectations.
module tb_dmem_burst_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [10:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0, rd_ready = 1'b0;
    logic        req_ready, wr_ready, rd_valid, done, mem_we;
    logic [15:0] rd_data, mem_d, mem_spo;
    logic [10:0] mem_a;

    typedef struct { logic [10:0] a; logic [15:0] d; } wexp_t;
    wexp_t       exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] ref_mem [0:2047];
    logic [15:0] mem [0:2047];
    logic        preload = 1'b0;
    logic [10:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    int checks = 0, errors = 0, done_seen = 0, done_exp = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [15:0] pd = '0;

    always #5 clk = ~clk;

    dmem_burst_master dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .done(done),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
    );

    // Memory responder: async read, sync write.
    always @(posedge clk) begin
        if (preload) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_a] <= mem_d;
    end
    assign mem_spo = mem[mem_a];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every memory write and every read handoff consumes one expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected actual=we@%0h expected=no_write", mem_a);
                end else begin
                    chk("wr_addr", 32'(mem_a), 32'(exp_wr[0].a));
                    chk("wr_data", 32'(mem_d), 32'(exp_wr[0].d));
                    void'(exp_wr.pop_front());
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected actual=%0h expected=no_word", rd_data);
                end else begin
                    chk("rd_data", 32'(rd_data), 32'(exp_rd[0]));
                    void'(exp_rd.pop_front());
                end
            end
            if (pv && !pr) begin
                chk("rd_hold_valid", 32'(rd_valid), 32'd1);
                chk("rd_hold_data", 32'(rd_data), 32'(pd));
            end
            if (done) done_seen <= done_seen + 1;
        end
        pv <= rd_valid && !reset;
        pr <= rd_ready;
        pd <= rd_data;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mem_a"}, 32'(mem_a), 32'd0);
        chk({tag, "_mem_d"}, 32'(mem_d), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    endtask

    task automatic do_write(input int a, input int len, input bit b2b, input bit hold,
                            input bit rnd, input logic [15:0] base,
                            output int we_run, output int done_lat);
        int cyc = 0, i = 0, run = 0, last_we = -1;
        bit accepted = 0, hs_req, hs_wr;
        logic [10:0] wa;
        we_run = 0; done_lat = -1;
        req_valid = 1; req_write = 1; req_addr = 11'(a); req_len = 4'(len); wr_valid = 0;
        while (cyc < 400) begin
            @(negedge clk);
            if (mem_we) begin run++; last_we = cyc; if (run > we_run) we_run = run; end
            else run = 0;
            if (done && accepted && i > len) begin done_lat = cyc - last_we; break; end
            hs_req = req_valid && req_ready && !accepted;
            hs_wr  = wr_valid && wr_ready;
            if (hs_wr) begin
                wa = 11'(a + i);
                exp_wr.push_back('{a: wa, d: wr_data});
                ref_mem[wa] = wr_data;
            end
            @(posedge clk); #1; cyc++;
            if (hs_req) accepted = 1;
            if (hs_wr) i++;
            if (accepted && hold && i <= len) begin
                req_addr = 11'($urandom); req_len = 4'($urandom); req_write = 1'($urandom);
            end else if (accepted) req_valid = 0;
            if (accepted && i <= len) begin
                wr_valid = b2b ? 1'b1 : 1'($urandom_range(0, 1));
                wr_data  = rnd ? 16'($urandom) : base + 16'(i);
            end else wr_valid = 0;
        end
        req_valid = 0; wr_valid = 0;
        if (done_lat >= 0) done_exp++;
        else chk("wr_timeout", 32'(i), 32'(len + 1));
    endtask

    task automatic do_read(input int a, input int len, input int mode, input bit noise,
                           input bit hold, output int first_lat, output int span,
                           output int done_lat);
        int cyc = 0, k = 0, acc = -1, first = -1, first_ho = -1, last_ho = -1, ho = 0;
        bit accepted = 0, hs_req, ho_now;
        first_lat = -1; span = -1; done_lat = -1;
        req_valid = 1; req_write = 0; req_addr = 11'(a); req_len = 4'(len);
        rd_ready = 1;
        while (cyc < 400) begin
            @(negedge clk);
            if (accepted && rd_valid && first < 0) first = cyc;
            if (done && accepted && ho > len) begin done_lat = cyc - last_ho; break; end
            hs_req = req_valid && req_ready && !accepted;
            if (hs_req) begin
                acc = cyc;
                for (int j = 0; j <= len; j++) exp_rd.push_back(ref_mem[11'(a + j)]);
            end
            ho_now = rd_valid && rd_ready;
            if (ho_now) begin
                ho++; last_ho = cyc;
                if (first_ho < 0) first_ho = cyc;
            end
            @(posedge clk); #1; cyc++; k++;
            if (hs_req) accepted = 1;
            if (accepted && hold && ho <= len) begin
                req_addr = 11'($urandom); req_len = 4'($urandom); req_write = 1'($urandom);
            end else if (accepted) req_valid = 0;
            rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
            wr_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            wr_data  = 16'($urandom);
        end
        req_valid = 0; wr_valid = 0; rd_ready = 0;
        if (first >= 0) first_lat = first - acc;
        if (first_ho >= 0) span = last_ho - first_ho;
        if (done_lat >= 0) done_exp++;
        else chk("rd_timeout", 32'(ho), 32'(len + 1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_run, dl, fl, sp, a, len, mism;
        // Preload random contents while the DUT is held in reset.
        preload = 1;
        for (int i = 0; i < 2048; i++) begin
            pl_addr = 11'(i); pl_data = 16'($urandom); ref_mem[i] = pl_data;
            @(posedge clk); #1;
        end
        preload = 0;
        @(negedge clk);
        chk_reset_vals("rst0");
        @(posedge clk); #1; reset = 0;

        // Reset mid write burst: word0 reaches memory, word1's write is squashed.
        req_valid = 1; req_write = 1; req_addr = 11'd100; req_len = 4'd7;
        @(negedge clk); chk("mid_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 0; wr_valid = 1; wr_data = 16'h5A00;
        exp_wr.push_back('{a: 11'd100, d: 16'h5A00}); ref_mem[100] = 16'h5A00;
        @(posedge clk); #1; wr_data = 16'h5A01;
        @(posedge clk); #1; reset = 1;
        @(negedge clk); chk("mid_rst_we", 32'(mem_we), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); chk_reset_vals("rst1");
        @(posedge clk); #1; reset = 0; wr_valid = 0;

        do_write(5, 3, 1, 0, 0, 16'hA001, wr_run, dl);
        chk("wr5_we_run", 32'(wr_run), 32'd4);
        chk("wr5_done_lat", 32'(dl), 32'd1);

        do_read(5, 3, 0, 0, 0, fl, sp, dl);
        chk("rd5_first_lat", 32'(fl), 32'd2);
        chk("rd5_span", 32'(sp), 32'd3);
        chk("rd5_done_lat", 32'(dl), 32'd1);

        do_read(5, 3, 1, 0, 0, fl, sp, dl);
        chk("rd5tog_done_lat", 32'(dl), 32'd1);
        do_read(100, 15, 1, 0, 0, fl, sp, dl);
        chk("rd100tog_first_lat", 32'(fl), 32'd2);

        do_write(2046, 2, 0, 0, 1, 16'h0, wr_run, dl);
        chk("wrap_wr_done_lat", 32'(dl), 32'd1);
        do_read(2046, 2, 0, 0, 0, fl, sp, dl);
        chk("wrap_rd_span", 32'(sp), 32'd2);

        // Busy requests and stray write-stream beats must be ignored.
        do_read(5, 3, 2, 1, 1, fl, sp, dl);
        chk("busy_rd_done_lat", 32'(dl), 32'd1);
        do_write(300, 5, 0, 1, 1, 16'h0, wr_run, dl);
        chk("busy_wr_done_lat", 32'(dl), 32'd1);

        for (int n = 0; n < 40; n++) begin
            a   = ($urandom_range(0, 3) == 0) ? 2040 + int'($urandom_range(0, 7))
                                              : int'($urandom_range(0, 63));
            len = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 16'h0,
                         wr_run, dl);
                chk("rnd_wr_done_lat", 32'(dl), 32'd1);
            end else begin
                do_read(a, len, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), fl, sp, dl);
                chk("rnd_rd_first_lat", 32'(fl), 32'd2);
                chk("rnd_rd_done_lat", 32'(dl), 32'd1);
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("end_wr_queue", 32'(exp_wr.size()), 32'd0);
        chk("end_rd_queue", 32'(exp_rd.size()), 32'd0);
        chk("done_count", 32'(done_seen), 32'(done_exp));
        mism = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_image_mismatches", 32'(mism), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
